alu_exec: RTL and testbench

Execute-stage ALU that consumes the 4-bit `aluop` produced by `alucontrol` together with the two decoded operands, and returns a registered result one cycle later. `ALUOP_MUL` and `ALUOP_DIV` run on a multi-cycle iterative unit. During that time the block deasserts `ready`, and the pipeline control logic uses it as an EX stall. Branch compares (`ALUOP_BEQ`/`ALUOP_BNE`) produce a registered `taken` flag for the PC-select logic.

---
 rtl/alu_exec.sv | 171 +++++++++++++++++
 tb/tb_alu_exec.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ops registered at accept, MUL/DIV on a shared
// 32-step radix-2 datapath. Define ALU_FAST_MUL_EN for a combinational MUL.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic             ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             taken,
  output logic             illegal
);

  localparam logic [3:0] ALUOP_ADD = 4'd0;
  localparam logic [3:0] ALUOP_SUB = 4'd1;
  localparam logic [3:0] ALUOP_AND = 4'd2;
  localparam logic [3:0] ALUOP_OR  = 4'd3;
  localparam logic [3:0] ALUOP_XOR = 4'd4;
  localparam logic [3:0] ALUOP_NOR = 4'd5;
  localparam logic [3:0] ALUOP_SLT = 4'd6;
  localparam logic [3:0] ALUOP_SLL = 4'd7;
  localparam logic [3:0] ALUOP_SRL = 4'd8;
  localparam logic [3:0] ALUOP_SRA = 4'd9;
  localparam logic [3:0] ALUOP_LUI = 4'd10;
  localparam logic [3:0] ALUOP_BEQ = 4'd11;
  localparam logic [3:0] ALUOP_BNE = 4'd12;
  localparam logic [3:0] ALUOP_MUL = 4'd13;
  localparam logic [3:0] ALUOP_DIV = 4'd14;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] acc;   // DIV: partial remainder, MUL: running sum
  logic [WIDTH-1:0] q;     // DIV: dividend/quotient, MUL: multiplier
  logic [WIDTH-1:0] d;     // DIV: divisor magnitude, MUL: shifted multiplicand
  logic             neg;
  logic             is_div;

  logic [WIDTH-1:0] sc_res;
  logic             sc_taken, sc_ill, go_iter;
  logic [WIDTH-1:0] abs_a, abs_b, fin_res;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] sub;
  logic             ge;

  assign ready = (state == S_IDLE);
  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;

  always_comb begin
    sc_res   = '0;
    sc_taken = 1'b0;
    sc_ill   = 1'b0;
    go_iter  = 1'b0;
    case (aluop)
      ALUOP_ADD: sc_res = a + b;
      ALUOP_SUB: sc_res = a - b;
      ALUOP_AND: sc_res = a & b;
      ALUOP_OR:  sc_res = a | b;
      ALUOP_XOR: sc_res = a ^ b;
      ALUOP_NOR: sc_res = ~(a | b);
      ALUOP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALUOP_SLL: sc_res = b << shamt;
      ALUOP_SRL: sc_res = b >> shamt;
      ALUOP_SRA: sc_res = $signed(b) >>> shamt;
      ALUOP_LUI: sc_res = {b[15:0], 16'h0000};
      ALUOP_BEQ: sc_taken = (a == b);
      ALUOP_BNE: sc_taken = (a != b);
`ifdef ALU_FAST_MUL_EN
      ALUOP_MUL: sc_res = a * b;
`else
      ALUOP_MUL: go_iter = 1'b1;
`endif
      ALUOP_DIV: begin
        // Divide by zero never enters the iterative unit.
        if (b == '0) sc_res = '1;
        else         go_iter = 1'b1;
      end
      default:   sc_ill = 1'b1;
    endcase
  end

  // Restoring divide step: shift next dividend bit into remainder, trial subtract.
  always_comb begin
    rem_sh = {acc, q[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, d});
    sub    = rem_sh[WIDTH-1:0] - d;
  end

  assign fin_res = is_div ? (neg ? -q : q) : acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      q         <= '0;
      d         <= '0;
      neg       <= 1'b0;
      is_div    <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      taken     <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: if (in_valid) begin
            if (go_iter) begin
              state  <= S_ITER;
              cnt    <= '0;
              acc    <= '0;
              is_div <= (aluop == ALUOP_DIV);
              neg    <= a[WIDTH-1] ^ b[WIDTH-1];
              q      <= (aluop == ALUOP_DIV) ? abs_a : a;
              d      <= (aluop == ALUOP_DIV) ? abs_b : b;
            end else begin
              result    <= sc_res;
              zero      <= (sc_res == '0);
              taken     <= sc_taken;
              illegal   <= sc_ill;
              out_valid <= 1'b1;
            end
          end
          S_ITER: begin
            if (is_div) begin
              acc <= ge ? sub : rem_sh[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], ge};
            end else begin
              if (q[0]) acc <= acc + d;
              d <= {d[WIDTH-2:0], 1'b0};
              q <= {1'b0, q[WIDTH-1:1]};
            end
            if (cnt == 6'd31) begin
              state <= S_FIN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
          S_FIN: begin
            result    <= fin_res;
            zero      <= (fin_res == '0);
            taken     <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Randomized bench for alu_exec against an arithmetic reference model with a
// per-cycle compare process and directed literal checks.
module tb_alu_exec;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_NOR = 4'd5,  OP_SLT = 4'd6,  OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8,  OP_SRA = 4'd9,  OP_LUI = 4'd10, OP_BEQ = 4'd11;
  localparam logic [3:0] OP_BNE = 4'd12, OP_MUL = 4'd13, OP_DIV = 4'd14, OP_BAD = 4'd15;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_EXTRA = 0;
`else
  localparam int MUL_EXTRA = 33;
`endif

  logic        clk = 1'b0, reset = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [3:0]  aluop = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  shamt = '0;
  logic        ready, out_valid, zero, taken, illegal;
  logic [31:0] result;

  alu_exec #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .aluop(aluop),
    .a(a), .b(b), .shamt(shamt), .ready(ready), .out_valid(out_valid),
    .result(result), .zero(zero), .taken(taken), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] res;
    logic        tk;
    logic        il;
  } exp_t;

  exp_t        expq[$];
  exp_t        e;
  int          checks = 0, errors = 0;
  int          cyc = 0, busy_until = 0;
  logic [31:0] last_res = '0;
  logic        last_zero = 1'b0, last_tk = 1'b0, last_il = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // extra = cycles beyond the single-cycle case until out_valid shows.
  function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                input logic [4:0] s, output logic [31:0] r, output logic tk,
                                output logic il, output int extra);
    longint unsigned p;
    longint          sq;
    r = '0; tk = 1'b0; il = 1'b0; extra = 0;
    case (op)
      OP_ADD: r = x + y;
      OP_SUB: r = x - y;
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_NOR: r = ~(x | y);
      OP_SLT: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      OP_SLL: r = y << s;
      OP_SRL: r = y >> s;
      OP_SRA: r = $signed(y) >>> s;
      OP_LUI: r = {y[15:0], 16'h0000};
      OP_BEQ: tk = (x == y);
      OP_BNE: tk = (x != y);
      OP_MUL: begin
        p = {32'h0, x} * {32'h0, y};
        r = p[31:0];
        extra = MUL_EXTRA;
      end
      OP_DIV: begin
        if (y == 32'h0) r = 32'hFFFF_FFFF;
        else begin
          sq = longint'($signed(x)) / longint'($signed(y));
          r = sq[31:0];
          extra = 33;
        end
      end
      default: il = 1'b1;
    endcase
  endfunction

  task automatic cycle(input logic iv, input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] s, input logic fl);
    logic [31:0] r;
    logic        tk, il, rdy;
    int          extra;
    in_valid = iv; aluop = op; a = x; b = y; shamt = s; flush = fl;
    rdy = (cyc >= busy_until);
    @(posedge clk);
    cyc++;
    if (fl) begin
      while (expq.size() > 0 && expq[expq.size()-1].due >= cyc) void'(expq.pop_back());
      if (busy_until > cyc) busy_until = cyc;
    end else if (iv && rdy && reset) begin
      model(op, x, y, s, r, tk, il, extra);
      expq.push_back('{due: cyc + extra, res: r, tk: tk, il: il});
      busy_until = cyc + extra;
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, OP_ADD, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic run_wait(output int n, output int nrdy);
    n = 0; nrdy = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      if (ready !== 1'b1) nrdy++;
      idle();
      n++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      chk("ready", {31'h0, ready}, {31'h0, (cyc >= busy_until)});
      if (expq.size() > 0 && expq[0].due < cyc) begin
        chk("missed_out_valid", 32'h0, 32'h1);
        void'(expq.pop_front());
      end
      if (expq.size() > 0 && expq[0].due == cyc) begin
        e = expq.pop_front();
        chk("out_valid", {31'h0, out_valid}, 32'h1);
        chk("result", result, e.res);
        chk("zero", {31'h0, zero}, {31'h0, (e.res == 32'h0)});
        chk("taken", {31'h0, taken}, {31'h0, e.tk});
        chk("illegal", {31'h0, illegal}, {31'h0, e.il});
        last_res = e.res; last_zero = (e.res == 32'h0); last_tk = e.tk; last_il = e.il;
      end else begin
        chk("out_valid_quiet", {31'h0, out_valid}, 32'h0);
        chk("result_hold", result, last_res);
        chk("flags_hold", {29'h0, zero, taken, illegal}, {29'h0, last_zero, last_tk, last_il});
      end
    end
  end

  initial begin
    int n, nr;
    logic [3:0] op;

    repeat (2) idle();
    chk("rst_ready", {31'h0, ready}, 32'h1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {29'h0, zero, taken, illegal}, 32'h0);
    reset = 1'b1;
    idle();

    cycle(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b0);
    chk("add_ov", {31'h0, out_valid}, 32'h1);
    chk("add_res", result, 32'h8000_0000);
    chk("add_zero_ill", {30'h0, zero, illegal}, 32'h0);
    chk("add_ready", {31'h0, ready}, 32'h1);

    cycle(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'h2, 5'd0, 1'b0);
    run_wait(n, nr);
    chk("div_lat", n, 33);
    chk("div_ready_low", nr, 33);
    chk("div_res", result, 32'hFFFF_FFFD);
    idle();

    cycle(1'b1, OP_DIV, 32'h1234, 32'h0, 5'd0, 1'b0);
    chk("div0_ov", {31'h0, out_valid}, 32'h1);
    chk("div0_res", result, 32'hFFFF_FFFF);

    cycle(1'b1, OP_MUL, 32'hFFFF_FFFF, 32'h3, 5'd0, 1'b0);
    run_wait(n, nr);
    chk("mul_lat", n, MUL_EXTRA);
    chk("mul_res", result, 32'hFFFF_FFFD);
    idle();

    cycle(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0);
    run_wait(n, nr);
    chk("div_ovf_res", result, 32'h8000_0000);
    idle();

    cycle(1'b1, OP_BEQ, 32'h5, 32'h5, 5'd0, 1'b0);
    chk("beq", {29'h0, taken, zero, illegal}, 32'h6);
    chk("beq_res", result, 32'h0);
    cycle(1'b1, OP_BNE, 32'h5, 32'h5, 5'd0, 1'b0);
    chk("bne_taken", {31'h0, taken}, 32'h0);
    cycle(1'b1, OP_BAD, 32'h9, 32'h9, 5'd0, 1'b0);
    chk("bad_ill", {30'h0, illegal, out_valid}, 32'h3);
    chk("bad_res", result, 32'h0);

    // async reset in the middle of a divide
    cycle(1'b1, OP_ADD, 32'h1, 32'h1, 5'd0, 1'b0);
    cycle(1'b1, OP_DIV, 32'd100, 32'd3, 5'd0, 1'b0);
    repeat (9) idle();
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", {31'h0, ready}, 32'h1);
    chk("mid_rst_out", {28'h0, out_valid, zero, taken, illegal}, 32'h0);
    chk("mid_rst_res", result, 32'h0);
    expq.delete();
    busy_until = cyc;
    last_res = '0; last_zero = 1'b0; last_tk = 1'b0; last_il = 1'b0;
    idle();
    reset = 1'b1;
    cycle(1'b1, OP_ADD, 32'd2, 32'd3, 5'd0, 1'b0);
    chk("post_rst_add", result, 32'd5);

    // flush at ITER step 5
    cycle(1'b1, OP_DIV, 32'd1000, 32'd7, 5'd0, 1'b0);
    repeat (4) idle();
    cycle(1'b0, OP_ADD, 32'h0, 32'h0, 5'd0, 1'b1);
    chk("flush_ready", {31'h0, ready}, 32'h1);
    chk("flush_ov", {31'h0, out_valid}, 32'h0);
    cycle(1'b1, OP_SLL, 32'h0, 32'h1, 5'd4, 1'b0);
    chk("sll_ov", {31'h0, out_valid}, 32'h1);
    chk("sll_res", result, 32'h10);
    repeat (40) idle();

    for (int i = 0; i < 4000; i++) begin
      op = 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 99) < 75, op, pick(), pick(), 5'($urandom_range(0, 31)),
            $urandom_range(0, 99) < 2);
    end
    repeat (40) idle();
    chk("queue_drained", expq.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
